// File: rtl/alu_serial_ctrl.sv
// Bit-serial 32-bit ALU sequencer driving a single 1-bit ALU slice, LSB first.
// Optional feature macro: ALU_SERIAL_NOR_EN (decode 1100 as NOR; otherwise illegal).
module alu_serial_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       ALU_control_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
   typedef enum logic [2:0] {
      K_AND = 3'd0, K_OR = 3'd1, K_ADD = 3'd2, K_SUB = 3'd3,
      K_SLT = 3'd4, K_NOR = 3'd5, K_ILL = 3'd6
   } kind_t;

   function automatic kind_t decode(input logic [3:0] code);
      case (code)
         4'b0000: decode = K_AND;
         4'b0001: decode = K_OR;
         4'b0010: decode = K_ADD;
         4'b0110: decode = K_SUB;
         4'b0111: decode = K_SLT;
`ifdef ALU_SERIAL_NOR_EN
         4'b1100: decode = K_NOR;
`endif
         default: decode = K_ILL;
      endcase
   endfunction

   // Behaviour of the 1-bit slice: returns {cout, result}.
   function automatic logic [1:0] slice(input logic a, input logic b, input logic a_inv,
                                        input logic b_inv, input logic [1:0] op, input logic cin);
      logic aa;
      logic bb;
      logic res;
      aa = a ^ a_inv;
      bb = b ^ b_inv;
      case (op)
         2'b00:   res = aa & bb;
         2'b01:   res = aa | bb;
         2'b10:   res = aa ^ bb ^ cin;
         default: res = 1'b0;
      endcase
      slice = {(aa & bb) | (aa & cin) | (bb & cin), res};
   endfunction

   state_t           state_r, state_nx;
   kind_t            kind_r, kind_s;
   logic [WIDTH-1:0] a_r, b_r, res_sh_r, fin_res_s;
   logic [CW-1:0]    cnt_r;
   logic             carry_r, cin_msb_r, sum_msb_r;
   logic             a_inv_s, b_inv_s, arith_s, ovf_s, set_s;
   logic [1:0]       slice_op_s, slice_out_s;
   logic [WIDTH-1:0] result_r;
   logic             zero_r, cout_r, overflow_r, busy_r, done_r;

   assign kind_s = decode(ALU_control_i);

   // Slice control from the latched operation class.
   always_comb begin
      a_inv_s    = 1'b0;
      b_inv_s    = 1'b0;
      slice_op_s = 2'b00;
      case (kind_r)
         K_OR:  slice_op_s = 2'b01;
         K_ADD: slice_op_s = 2'b10;
         K_SUB, K_SLT: begin
            b_inv_s    = 1'b1;
            slice_op_s = 2'b10;
         end
         K_NOR: begin
`ifdef ALU_SERIAL_NOR_EN
            a_inv_s = 1'b1;
`else
            a_inv_s = 1'b0;
`endif
            b_inv_s = 1'b1;
         end
         default: slice_op_s = 2'b00;
      endcase
   end

   assign slice_out_s = slice(a_r[0], b_r[0], a_inv_s, b_inv_s, slice_op_s, carry_r);

   // Flag resolution used in the finishing cycle.
   always_comb begin
      arith_s = (kind_r == K_ADD) || (kind_r == K_SUB) || (kind_r == K_SLT);
      ovf_s   = arith_s & (cin_msb_r ^ carry_r);
      set_s   = sum_msb_r ^ ovf_s;
      if (kind_r == K_SLT) begin
         fin_res_s = {{(WIDTH-1){1'b0}}, set_s};
      end else if (kind_r == K_ILL) begin
         fin_res_s = '0;
      end else begin
         fin_res_s = res_sh_r;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_r <= IDLE;
      else        state_r <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) state_nx = RUN;
            else         state_nx = IDLE;
         end
         RUN: begin
            if (cnt_r == LAST) state_nx = FIN;
            else               state_nx = RUN;
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand shifting, carry chain and registered outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         kind_r     <= K_AND;
         a_r        <= '0;
         b_r        <= '0;
         res_sh_r   <= '0;
         cnt_r      <= '0;
         carry_r    <= 1'b0;
         cin_msb_r  <= 1'b0;
         sum_msb_r  <= 1'b0;
         result_r   <= '0;
         zero_r     <= 1'b1;
         cout_r     <= 1'b0;
         overflow_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  kind_r  <= kind_s;
                  a_r     <= (kind_s == K_ILL) ? '0 : src1_i;
                  b_r     <= (kind_s == K_ILL) ? '0 : src2_i;
                  cnt_r   <= '0;
                  carry_r <= (kind_s == K_SUB) || (kind_s == K_SLT);
                  busy_r  <= 1'b1;
               end
            end
            RUN: begin
               a_r      <= a_r >> 1;
               b_r      <= b_r >> 1;
               res_sh_r <= {slice_out_s[0], res_sh_r[WIDTH-1:1]};
               carry_r  <= slice_out_s[1];
               cnt_r    <= cnt_r + CW'(1);
               if (cnt_r == LAST) begin
                  cin_msb_r <= carry_r;
                  sum_msb_r <= slice_out_s[0];
               end
            end
            FIN: begin
               result_r   <= fin_res_s;
               zero_r     <= (fin_res_s == '0);
               cout_r     <= arith_s & carry_r;
               overflow_r <= (kind_r == K_SLT) ? 1'b0 : ovf_s;
               busy_r     <= 1'b0;
               done_r     <= 1'b1;
            end
            default: done_r <= 1'b0;
         endcase
      end
   end

   assign result_o   = result_r;
   assign zero_o     = zero_r;
   assign cout_o     = cout_r;
   assign overflow_o = overflow_r;
   assign busy_o     = busy_r;
   assign done_o     = done_r;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed table, corner sequences, random ops vs. a
// plain-arithmetic reference model.
module tb_alu_serial_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] src1_i, src2_i;
   logic [3:0]  ALU_control_i;
   logic [31:0] result_o;
   logic        zero_o, cout_o, overflow_o, busy_o, done_o;

   int total = 0;
   int bad   = 0;

   alu_serial_ctrl #(.WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .src1_i(src1_i), .src2_i(src2_i), .ALU_control_i(ALU_control_i),
      .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o),
      .overflow_o(overflow_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        z;
      logic        c;
      logic        v;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference model straight from the arithmetic definitions.
   function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      vec_t m;
      logic [32:0] wide;
      m.op = op; m.a = a; m.b = b; m.c = 1'b0; m.v = 1'b0; m.r = 32'd0;
      case (op)
         4'b0000: m.r = a & b;
         4'b0001: m.r = a | b;
         4'b0010: begin
            wide = {1'b0, a} + {1'b0, b};
            m.r = wide[31:0]; m.c = wide[32];
            m.v = (a[31] == b[31]) && (m.r[31] != a[31]);
         end
         4'b0110: begin
            wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
            m.r = wide[31:0]; m.c = wide[32];
            m.v = (a[31] != b[31]) && (m.r[31] != a[31]);
         end
         4'b0111: begin
            wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
            m.c = wide[32];
            m.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         end
`ifdef ALU_SERIAL_NOR_EN
         4'b1100: m.r = ~(a | b);
`endif
         default: m.r = 32'd0;
      endcase
      m.z = (m.r == 32'd0);
      return m;
   endfunction

   // Issue one op, wait (bounded) for done; report latency and sampled values.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_after, output logic [31:0] res_after);
      src1_i = a; src2_i = b; ALU_control_i = op; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      busy_after = busy_o;
      res_after = result_o;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk_i); #1;
         if (done_o) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic check_out(input string tag, input vec_t e);
      chk({tag, "_res"}, result_o, e.r);
      chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, e.z});
      chk({tag, "_cout"}, {31'd0, cout_o}, {31'd0, e.c});
      chk({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, e.v});
   endtask

   vec_t        tbl[10];
   vec_t        e;
   int          lat, dones, t0, t1;
   logic        busy_after;
   logic [31:0] res_after, prev_res, seen_res;
   logic [31:0] corner[5];
   logic [3:0]  codes[7];

   initial begin
      tbl[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{4'b0111, 32'h00000003, 32'h00000002, 32'h00000000, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
`ifdef ALU_SERIAL_NOR_EN
      tbl[7] = '{4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0, 1'b0};
`else
      tbl[7] = '{4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 1'b1, 1'b0, 1'b0};
`endif
      tbl[8] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
      tbl[9] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
      corner = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
      codes  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000};

      rst_i = 1'b0; start_i = 1'b0; src1_i = 32'd0; src2_i = 32'd0; ALU_control_i = 4'd0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_res", result_o, 32'd0);
      chk("rst_flags", {26'd0, zero_o, cout_o, overflow_o, busy_o, done_o, 1'b0}, {26'd0, 6'b100000});
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      prev_res = 32'd0;
      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, busy_after, res_after);
         chk($sformatf("tbl%0d_lat", i), lat, 33);
         chk($sformatf("tbl%0d_busy_rise", i), {31'd0, busy_after}, 32'd1);
         chk($sformatf("tbl%0d_busy_fall", i), {31'd0, busy_o}, 32'd0);
         chk($sformatf("tbl%0d_hold_at_accept", i), res_after, prev_res);
         check_out($sformatf("tbl%0d", i), tbl[i]);
         prev_res = tbl[i].r;
      end

      repeat (5) @(posedge clk_i);
      #1;
      chk("idle_hold_res", result_o, prev_res);
      chk("idle_done_low", {31'd0, done_o}, 32'd0);

      // start pulsed mid-RUN must be ignored
      src1_i = 32'd100; src2_i = 32'd23; ALU_control_i = 4'b0010; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      dones = 0; seen_res = 32'd0;
      for (int i = 1; i <= 50; i++) begin
         @(posedge clk_i); #1;
         if (i == 10) begin
            start_i = 1'b1; src1_i = 32'h0000FFFF; ALU_control_i = 4'b0000;
         end
         if (i == 11) start_i = 1'b0;
         if (done_o) begin
            dones++;
            seen_res = result_o;
         end
      end
      chk("busy_start_dones", dones, 1);
      chk("busy_start_res", seen_res, 32'd123);
      do_op(4'b0010, 32'd7, 32'd8, lat, busy_after, res_after);
      chk("reissue_lat", lat, 33);
      chk("reissue_res", result_o, 32'd15);

      // start held high: FIN must not accept, so accepts are 34 cycles apart
      src1_i = 32'd1; src2_i = 32'd2; ALU_control_i = 4'b0010; start_i = 1'b1;
      t0 = 0; t1 = 0; dones = 0;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk_i); #1;
         if (done_o) begin
            if (dones == 0) t0 = i;
            else if (dones == 1) t1 = i;
            dones++;
         end
      end
      start_i = 1'b0;
      repeat (40) @(posedge clk_i);
      #1;
      chk("b2b_first", t0, 34);
      chk("b2b_second", t1, 68);

      for (int n = 0; n < 40; n++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = codes[$urandom_range(0, 6)];
         if (n % 7 == 6) op = 4'($urandom_range(0, 15));
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         e = model(op, a, b);
         do_op(op, a, b, lat, busy_after, res_after);
         chk($sformatf("rnd%0d_lat", n), lat, 33);
         check_out($sformatf("rnd%0d_op%h", n, op), e);
      end

      // async reset in the middle of a SUB
      do_op(4'b0010, 32'd40, 32'd2, lat, busy_after, res_after);
      src1_i = 32'd9; src2_i = 32'd4; ALU_control_i = 4'b0110; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (14) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      chk("midrst_res", result_o, 32'd0);
      chk("midrst_flags", {26'd0, zero_o, cout_o, overflow_o, busy_o, done_o, 1'b0}, {26'd0, 6'b100000});
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i); #1;
         if (done_o) dones++;
      end
      chk("midrst_no_done", dones, 0);
      do_op(4'b0010, 32'd2, 32'd3, lat, busy_after, res_after);
      chk("after_rst_lat", lat, 33);
      chk("after_rst_res", result_o, 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
